// File: rtl/ip_tx_pkg.sv
// ----------------------------------------------------------------------------
// ip_tx_pkg
// Shared definitions for the IP transmit path: the arbiter state encoding and
// the payload widths that both the arbiter and the ip_packet_tx framer use.
// No ports (package).
// ----------------------------------------------------------------------------
package ip_tx_pkg;

  localparam int IP_ADDR_W    = 32;
  localparam int MAC_ADDR_W   = 48;
  localparam int ACCEL_DATA_W = 10;
  localparam int AXIS_DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Starting at index ptr and searching
// upward (wrapping at NUM_REQ), the first asserted request wins. Kept generic
// so other shared MAC-side resources can reuse it.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    highest-priority index for this cycle (< NUM_REQ)
//   grant      out  NUM_REQ  one-hot grant, all zero when no request
//   grant_idx  out  IDX_W    encoded winner index, 0 when no request
//   grant_vld  out  1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    // Offset k = 0 is the pointer itself; the first hit in offset order wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ip_tx_arbiter
// Shares one ip_packet_tx framer between NUM_REQ requesters. Round-robin grant
// while the framer is idle, captures the winner's recipient IP/MAC/message and
// holds them for the whole frame, issues a one-cycle start strobe, then waits
// for the last MAC beat (valid & ready & last) before granting again.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for framer ready and a request; grant happens here
//   START  | TX_START_IP_TXN high for this single cycle
//   BUSY   | frame in flight; payload held until the last MAC beat
//
// Ports (requester i occupies slice [i*W +: W] of the flattened vectors):
//   ACLK                      in   1                 clock, rising edge
//   ARESET                    in   1                 async reset, active low
//   REQ_VALID                 in   NUM_REQ           message pending
//   REQ_READY                 out  NUM_REQ           one-hot accept pulse
//   REQ_IP_ADDRESS            in   NUM_REQ*IP        recipient IP per requester
//   REQ_MAC_ADDRESS           in   NUM_REQ*MAC       recipient MAC per requester
//   REQ_MESSAGE               in   NUM_REQ*MSG       message per requester
//   TX_RECIPIENT_IP_ADDRESS   out  IP                captured IP to framer
//   TX_RECIPIENT_MAC_ADDRESS  out  MAC               captured MAC to framer
//   TX_RECIPIENT_MESSAGE      out  MSG               captured message to framer
//   TX_START_IP_TXN           out  1                 registered start strobe
//   TX_READY_FOR_SEND         in   1                 framer idle
//   MAC_DATA_VALID/READY/LAST in   1 each            monitored MAC handshake
//   BUSY                      out  1                 frame granted or in flight
//   GRANT_ID                  out  clog2(NUM_REQ)    current/last grantee
//   TXN_COUNT                 out  16                completed frames, wraps
// ----------------------------------------------------------------------------
module ip_tx_arbiter
  import ip_tx_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int IP_ADDR_WIDTH    = IP_ADDR_W,
  parameter int MAC_ADDR_WIDTH   = MAC_ADDR_W,
  parameter int ACCEL_DATA_WIDTH = ACCEL_DATA_W
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [NUM_REQ-1:0]                    REQ_VALID,
  output logic [NUM_REQ-1:0]                    REQ_READY,
  input  logic [NUM_REQ*IP_ADDR_WIDTH-1:0]      REQ_IP_ADDRESS,
  input  logic [NUM_REQ*MAC_ADDR_WIDTH-1:0]     REQ_MAC_ADDRESS,
  input  logic [NUM_REQ*ACCEL_DATA_WIDTH-1:0]   REQ_MESSAGE,
  output logic [IP_ADDR_WIDTH-1:0]              TX_RECIPIENT_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]             TX_RECIPIENT_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0]           TX_RECIPIENT_MESSAGE,
  output logic                                  TX_START_IP_TXN,
  input  logic                                  TX_READY_FOR_SEND,
  input  logic                                  MAC_DATA_VALID,
  input  logic                                  MAC_DATA_READY,
  input  logic                                  MAC_DATA_LAST,
  output logic                                  BUSY,
  output logic [$clog2(NUM_REQ)-1:0]            GRANT_ID,
  output logic [15:0]                           TXN_COUNT
);

  localparam int ID_W = $clog2(NUM_REQ);

  tx_state_e           state;
  tx_state_e           state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_vld;
  logic                grant_take;
  logic                frame_done;
  logic                last_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_arbiter (
    .req       (REQ_VALID),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign last_beat = MAC_DATA_VALID & MAC_DATA_READY & MAC_DATA_LAST;

  // The accept pulse is combinational from REQ_VALID; it is also qualified by
  // the reset pin so no requester sees an accept while the block is held in
  // reset (state already reads IDLE then).
  assign REQ_READY = (grant_take && ARESET) ? arb_grant : '0;

  assign BUSY = (state != ST_IDLE);

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state           <= ST_IDLE;
      TX_START_IP_TXN <= 1'b0;
    end else begin
      state           <= state_nxt;
      // Registered from next-state so the strobe covers exactly the START cycle.
      TX_START_IP_TXN <= (state_nxt == ST_START);
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (TX_READY_FOR_SEND && arb_vld) begin
          grant_take = 1'b1;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (last_beat) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      TX_RECIPIENT_IP_ADDRESS  <= '0;
      TX_RECIPIENT_MAC_ADDRESS <= '0;
      TX_RECIPIENT_MESSAGE     <= '0;
      GRANT_ID                 <= '0;
      rr_ptr                   <= '0;
      TXN_COUNT                <= '0;
    end else begin
      if (grant_take) begin
        TX_RECIPIENT_IP_ADDRESS  <= REQ_IP_ADDRESS[arb_idx*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
        TX_RECIPIENT_MAC_ADDRESS <= REQ_MAC_ADDRESS[arb_idx*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
        TX_RECIPIENT_MESSAGE     <= REQ_MESSAGE[arb_idx*ACCEL_DATA_WIDTH +: ACCEL_DATA_WIDTH];
        GRANT_ID                 <= arb_idx;
        // Winner drops to lowest priority for the next arbitration.
        if (arb_idx == ID_W'(NUM_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= arb_idx + ID_W'(1);
        end
      end
      if (frame_done) begin
        TXN_COUNT <= TXN_COUNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
module tb_ip_tx_arbiter;

  localparam int NR   = 2;
  localparam int IPW  = 32;
  localparam int MACW = 48;
  localparam int MSGW = 10;

  logic                  ACLK;
  logic                  ARESET;
  logic [NR-1:0]         REQ_VALID;
  logic [NR-1:0]         REQ_READY;
  logic [NR*IPW-1:0]     REQ_IP_ADDRESS;
  logic [NR*MACW-1:0]    REQ_MAC_ADDRESS;
  logic [NR*MSGW-1:0]    REQ_MESSAGE;
  logic [IPW-1:0]        TX_RECIPIENT_IP_ADDRESS;
  logic [MACW-1:0]       TX_RECIPIENT_MAC_ADDRESS;
  logic [MSGW-1:0]       TX_RECIPIENT_MESSAGE;
  logic                  TX_START_IP_TXN;
  logic                  TX_READY_FOR_SEND;
  logic                  MAC_DATA_VALID;
  logic                  MAC_DATA_READY;
  logic                  MAC_DATA_LAST;
  logic                  BUSY;
  logic [$clog2(NR)-1:0] GRANT_ID;
  logic [15:0]           TXN_COUNT;

  logic [IPW-1:0]  tb_ip  [NR];
  logic [MACW-1:0] tb_mac [NR];
  logic [MSGW-1:0] tb_msg [NR];

  int total = 0;
  int bad   = 0;

  // Reference model: round-robin pointer and completed-frame count.
  int          m_ptr   = 0;
  logic [15:0] m_count = 16'd0;

  ip_tx_arbiter #(
    .NUM_REQ          (NR),
    .IP_ADDR_WIDTH    (IPW),
    .MAC_ADDR_WIDTH   (MACW),
    .ACCEL_DATA_WIDTH (MSGW)
  ) dut (
    .ACLK                     (ACLK),
    .ARESET                   (ARESET),
    .REQ_VALID                (REQ_VALID),
    .REQ_READY                (REQ_READY),
    .REQ_IP_ADDRESS           (REQ_IP_ADDRESS),
    .REQ_MAC_ADDRESS          (REQ_MAC_ADDRESS),
    .REQ_MESSAGE              (REQ_MESSAGE),
    .TX_RECIPIENT_IP_ADDRESS  (TX_RECIPIENT_IP_ADDRESS),
    .TX_RECIPIENT_MAC_ADDRESS (TX_RECIPIENT_MAC_ADDRESS),
    .TX_RECIPIENT_MESSAGE     (TX_RECIPIENT_MESSAGE),
    .TX_START_IP_TXN          (TX_START_IP_TXN),
    .TX_READY_FOR_SEND        (TX_READY_FOR_SEND),
    .MAC_DATA_VALID           (MAC_DATA_VALID),
    .MAC_DATA_READY           (MAC_DATA_READY),
    .MAC_DATA_LAST            (MAC_DATA_LAST),
    .BUSY                     (BUSY),
    .GRANT_ID                 (GRANT_ID),
    .TXN_COUNT                (TXN_COUNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always_comb begin
    REQ_IP_ADDRESS  = '0;
    REQ_MAC_ADDRESS = '0;
    REQ_MESSAGE     = '0;
    for (int i = 0; i < NR; i++) begin
      REQ_IP_ADDRESS[i*IPW +: IPW]    = tb_ip[i];
      REQ_MAC_ADDRESS[i*MACW +: MACW] = tb_mac[i];
      REQ_MESSAGE[i*MSGW +: MSGW]     = tb_msg[i];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // First set bit searching upward from ptr, wrapping.
  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk_payload(input string tag, input logic [IPW-1:0] ip,
                             input logic [MACW-1:0] mac, input logic [MSGW-1:0] msg);
    chk({tag, "_ip"},  TX_RECIPIENT_IP_ADDRESS,  ip);
    chk({tag, "_mac"}, TX_RECIPIENT_MAC_ADDRESS, mac);
    chk({tag, "_msg"}, TX_RECIPIENT_MESSAGE,     msg);
  endtask

  task automatic randomize_payloads();
    for (int i = 0; i < NR; i++) begin
      tb_ip[i]  = $urandom;
      tb_mac[i] = {16'($urandom), $urandom};
      tb_msg[i] = MSGW'($urandom);
    end
  endtask

  // Runs one complete frame. Entered and left just after a falling edge with
  // the DUT idle. exp_id < 0 means the expected winner comes from the model.
  task automatic do_frame(input logic [NR-1:0] rv, input int exp_id, input int beats,
                          input int stall, input int nrdy, input bit drop_valid);
    int w;
    logic [NR-1:0]   oh;
    logic [IPW-1:0]  e_ip;
    logic [MACW-1:0] e_mac;
    logic [MSGW-1:0] e_msg;
    REQ_VALID      = rv;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_READY = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    TX_READY_FOR_SEND = 1'b0;
    for (int c = 0; c < nrdy; c++) begin
      #1;
      chk("nrdy_req_ready", REQ_READY, '0);
      chk("nrdy_busy", BUSY, 1'b0);
      chk("nrdy_start", TX_START_IP_TXN, 1'b0);
      @(negedge ACLK);
    end
    TX_READY_FOR_SEND = 1'b1;
    w = (exp_id >= 0) ? exp_id : pick(rv, m_ptr);
    oh = '0;
    oh[w] = 1'b1;
    e_ip  = tb_ip[w];
    e_mac = tb_mac[w];
    e_msg = tb_msg[w];
    #1;
    chk("grant_req_ready", REQ_READY, oh);
    chk("grant_busy", BUSY, 1'b0);
    @(negedge ACLK);
    chk("start_strobe", TX_START_IP_TXN, 1'b1);
    chk("start_busy", BUSY, 1'b1);
    chk("start_req_ready", REQ_READY, '0);
    chk("start_grant_id", GRANT_ID, w);
    chk_payload("start", e_ip, e_mac, e_msg);
    m_ptr = (w + 1) % NR;
    // Inputs change after the grant edge; captured payload must not follow.
    randomize_payloads();
    if (drop_valid) REQ_VALID = rv & ~oh;
    TX_READY_FOR_SEND = 1'b0;
    @(negedge ACLK);
    chk("post_start_strobe", TX_START_IP_TXN, 1'b0);
    chk("post_start_busy", BUSY, 1'b1);
    for (int b = 0; b < beats; b++) begin
      if (b == beats - 1) begin
        for (int s = 0; s < stall; s++) begin
          MAC_DATA_VALID = 1'b1;
          MAC_DATA_READY = 1'b0;
          MAC_DATA_LAST  = 1'b1;
          @(negedge ACLK);
          chk("stall_busy", BUSY, 1'b1);
          chk("stall_req_ready", REQ_READY, '0);
          chk("stall_start", TX_START_IP_TXN, 1'b0);
          chk("stall_grant_id", GRANT_ID, w);
          chk_payload("stall", e_ip, e_mac, e_msg);
        end
      end
      MAC_DATA_VALID = 1'b1;
      MAC_DATA_READY = 1'b1;
      MAC_DATA_LAST  = (b == beats - 1);
      @(negedge ACLK);
      if (b != beats - 1) begin
        chk("beat_busy", BUSY, 1'b1);
        chk("beat_count", TXN_COUNT, m_count);
        chk_payload("beat", e_ip, e_mac, e_msg);
      end
    end
    m_count = m_count + 16'd1;
    chk("done_busy", BUSY, 1'b0);
    chk("done_count", TXN_COUNT, m_count);
    chk_payload("done", e_ip, e_mac, e_msg);
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_READY = 1'b0;
    MAC_DATA_LAST  = 1'b0;
  endtask

  initial begin
    int w;
    logic [NR-1:0] rv;
    ARESET = 1'b0;
    REQ_VALID = 2'b11;
    TX_READY_FOR_SEND = 1'b1;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_READY = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    randomize_payloads();

    // Reset state, with requests pending and framer ready.
    #2;
    chk("rst_req_ready", REQ_READY, '0);
    chk("rst_start", TX_START_IP_TXN, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_grant_id", GRANT_ID, '0);
    chk("rst_count", TXN_COUNT, '0);
    chk_payload("rst", '0, '0, '0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;

    // Simultaneous requests: 0 first, then 1 straight after.
    do_frame(2'b11, 0, 3, 0, 0, 1'b1);
    do_frame(2'b10, 1, 2, 0, 0, 1'b0);

    // Single request from requester 1 with fixed payload.
    tb_ip[1]  = 32'h0A00_0002;
    tb_mac[1] = 48'h02AA_BBCC_DDEE;
    tb_msg[1] = 10'h2A5;
    do_frame(2'b10, 1, 4, 0, 0, 1'b0);

    // Persistent requests: strict alternation over six frames.
    for (int f = 0; f < 6; f++) begin
      do_frame(2'b11, f % 2, 2, 0, 0, 1'b0);
    end
    chk("persist_count", TXN_COUNT, 16'd9);

    // Backpressure: ready low for 10 cycles before the last beat.
    do_frame(2'b11, 0, 3, 10, 0, 1'b0);

    // Framer not ready for 5 cycles with both pending.
    do_frame(2'b11, 1, 2, 0, 5, 1'b0);

    // Reset while BUSY.
    REQ_VALID = 2'b01;
    TX_READY_FOR_SEND = 1'b1;
    #1;
    chk("rb_grant", REQ_READY, 2'b01);
    @(negedge ACLK);
    chk("rb_start", TX_START_IP_TXN, 1'b1);
    REQ_VALID = 2'b11;
    @(negedge ACLK);
    chk("rb_busy", BUSY, 1'b1);
    MAC_DATA_VALID = 1'b1;
    MAC_DATA_READY = 1'b0;
    MAC_DATA_LAST  = 1'b1;
    ARESET = 1'b0;
    #1;
    chk("rb_rst_busy", BUSY, 1'b0);
    chk("rb_rst_start", TX_START_IP_TXN, 1'b0);
    chk("rb_rst_req_ready", REQ_READY, '0);
    chk("rb_rst_grant_id", GRANT_ID, '0);
    chk("rb_rst_count", TXN_COUNT, '0);
    chk_payload("rb_rst", '0, '0, '0);
    MAC_DATA_READY = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rb_hold_count", TXN_COUNT, '0);
    chk("rb_hold_busy", BUSY, 1'b0);
    ARESET = 1'b1;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_READY = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    m_ptr   = 0;
    m_count = 16'd0;
    do_frame(2'b11, 0, 2, 0, 0, 1'b0);

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) begin
      rv = NR'($urandom_range(1, 3));
      randomize_payloads();
      w = pick(rv, m_ptr);
      do_frame(rv, -1, $urandom_range(1, 4), $urandom_range(0, 3),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    chk("final_count", TXN_COUNT, m_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
